// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter
//   Shares one single-port user BRAM between the management SoC Wishbone
//   slave path and a DMA/engine master port. Each granted request becomes a
//   fixed-latency BRAM access of DELAYS cycles followed by a one-cycle
//   response, where the still-requesting owner gets a one-cycle ack plus
//   read data.
//
//   Build option ARB_WB_PRIORITY_EN:
//     defined   - Wishbone wins every tie (fixed priority)
//     undefined - ties alternate against the last granted requester
//
//   Ports
//     wb_clk_i, wb_rst_i          clock, async active-high reset
//     wbs_cyc/stb/we/sel/adr/dat  Wishbone slave request inputs
//     wbs_ack_o, wbs_dat_o        Wishbone ack pulse and read data
//     dma_req/we/adr/dat_i        DMA level request (held until ack)
//     dma_ack_o, dma_dat_o        DMA ack pulse and read data
//     bram_en/we/adr/di_o         BRAM control, address and write data
//     bram_do_i                   BRAM read data
//     busy_o                      high whenever not idle
//
//   Timing: the request is registered at the first edge after it appears;
//   the ack is combinational during the RESP cycle, so with the request
//   asserted in cycle 1 the ack is high in cycle DELAYS+2. Because the ack
//   is seen in RESP, a master that drops its request at the following edge
//   is gone before IDLE samples again; a master that keeps it asserted
//   starts a new transaction.
//
//   state  | meaning
//   IDLE   | no access in progress, arbitrate pending requests
//   ACCESS | BRAM enabled for DELAYS cycles, write strobes on first cycle
//   RESP   | one-cycle ack to owner if it still requests
module bram_access_arbiter #(
  parameter int          DELAYS  = 10,
  parameter logic [15:0] BASE_HI = 16'h3800,
  parameter int          ADDR_W  = 12
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_adr_i,
  input  logic [31:0]       dma_dat_i,
  output logic              dma_ack_o,
  output logic [31:0]       dma_dat_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_adr_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_WB  = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_owner;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_wdat;
  logic [31:0]       r_rdata;
`ifndef ARB_WB_PRIORITY_EN
  logic              r_last_grant;
`endif

  logic w_wb_req;
  logic w_grant_dma;
  logic w_access;
  logic w_resp;
  logic w_unused_adr;

  assign w_wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_HI);

  // Window bits between the BRAM offset and the base compare are ignored.
  assign w_unused_adr = ^wbs_adr_i[15:0];

  always_comb begin
    w_grant_dma = 1'b0;
    if (w_wb_req && dma_req_i) begin
`ifdef ARB_WB_PRIORITY_EN
      w_grant_dma = 1'b0;
`else
      w_grant_dma = (r_last_grant == OWN_WB);
`endif
    end else begin
      w_grant_dma = dma_req_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_owner      <= OWN_WB;
      r_we         <= 1'b0;
      r_sel        <= 4'd0;
      r_adr        <= '0;
      r_wdat       <= 32'd0;
      r_rdata      <= 32'd0;
`ifndef ARB_WB_PRIORITY_EN
      r_last_grant <= OWN_DMA;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wb_req || dma_req_i) begin
            r_cnt   <= 4'd0;
            r_state <= S_ACCESS;
            if (w_grant_dma) begin
              r_owner <= OWN_DMA;
              r_we    <= dma_we_i;
              r_sel   <= 4'hF;
              r_adr   <= dma_adr_i;
              r_wdat  <= dma_dat_i;
            end else begin
              r_owner <= OWN_WB;
              r_we    <= wbs_we_i;
              r_sel   <= wbs_sel_i;
              r_adr   <= wbs_adr_i[ADDR_W-1:0];
              r_wdat  <= wbs_dat_i;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'(DELAYS - 1)) begin
            r_rdata <= bram_do_i;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
`ifndef ARB_WB_PRIORITY_EN
          r_last_grant <= r_owner;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  assign bram_en_o  = w_access;
  // Write strobes only on the first access cycle so each write lands once.
  assign bram_we_o  = (w_access && r_we && (r_cnt == 4'd0)) ? r_sel : 4'd0;
  assign bram_adr_o = {{(32-ADDR_W){1'b0}}, r_adr};
  assign bram_di_o  = r_wdat;

  // Ack only if the owner still requests; a withdrawn request is dropped.
  assign wbs_ack_o = w_resp && (r_owner == OWN_WB) && w_wb_req;
  assign dma_ack_o = w_resp && (r_owner == OWN_DMA) && dma_req_i;
  assign wbs_dat_o = wbs_ack_o ? r_rdata : 32'd0;
  assign dma_dat_o = dma_ack_o ? r_rdata : 32'd0;

  assign busy_o = (r_state != S_IDLE);

endmodule
